// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size encodings and controller state for the byte-enabled data memory
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic {CLEAR, IDLE} state_t;
endpackage

// File: rtl/data_memory_be_if.sv
// data_memory_be_if: load/store bus between a core and the data memory
interface data_memory_be_if #(parameter int TST_W = 16);
  logic [31:0] A;
  logic [31:0] WD;
  logic WE;
  logic RE;
  logic [1:0] SIZE;
  logic SGN;
  logic clr;
  logic [31:0] RD;
  logic busy;
  logic misalign;
  logic range_err;
  logic [TST_W-1:0] tst;
  modport master (output A, WD, WE, RE, SIZE, SGN, clr, input RD, busy, misalign, range_err, tst);
  modport slave (input A, WD, WE, RE, SIZE, SGN, clr, output RD, busy, misalign, range_err, tst);
endinterface

// File: rtl/dmem_align.sv
// dmem_align: byte-lane enables, store replication, load extract/extend and misalignment detect
module dmem_align import dmem_pkg::*; (
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wd,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic word;
  logic half;
  logic [7:0] b;
  logic [15:0] h;
  assign half = size == SZ_HALF;
  assign word = size != SZ_BYTE && !half;
  assign misalign = half ? a[0] : word && a != 2'b00;
  assign be = word ? 4'hF : half ? (a[1] ? 4'hC : 4'h3) : 4'b0001 << a;
  assign wdata = word ? wd : half ? {2{wd[15:0]}} : {4{wd[7:0]}};
  assign b = 8'(rword >> {a, 3'b000});
  assign h = a[1] ? rword[31:16] : rword[15:0];
  assign rdata = word ? rword : half ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: word-organised data memory with byte/half/word access and a self-clearing sequencer
module data_memory_be import dmem_pkg::*; #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_REG = 0,
  parameter int TST_W  = 16
) (
  input logic clk,
  input logic rst,
  data_memory_be_if.slave bus
);
  logic [31:0] mem [DEPTH];
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] idx;
  logic [3:0] be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] rd_c;
  logic [31:0] rd_q;
  logic busy;
  logic st;
  assign idx = bus.A[ADDR_W+1:2];
  assign busy = state == CLEAR;
  assign bus.busy = busy;
  assign bus.range_err = {2'b00, bus.A[31:2]} >= 32'(DEPTH);
  assign st = !busy && bus.WE && !bus.clr && !bus.misalign && !bus.range_err;
  assign rd_c = (bus.misalign || bus.range_err) ? '0 : rdata;
  assign bus.RD = busy ? '0 : (RD_REG != 0 ? rd_q : rd_c);
  assign bus.tst = busy ? '0 : mem[0][TST_W-1:0];
  dmem_align u_align (
    .a(bus.A[1:0]),
    .size(bus.SIZE),
    .sgn(bus.SGN),
    .wd(bus.WD),
    .rword(mem[idx]),
    .be(be),
    .wdata(wdata),
    .rdata(rdata),
    .misalign(bus.misalign)
  );
  // controller state and clear pointer; reset restarts the clear sweep at word 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // clear sweeps every word once, idle accepts a clear request (which overrides a store)
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == CLEAR) begin
      cnt_n = cnt + ADDR_W'(1);
      state_n = cnt == ADDR_W'(DEPTH - 1) ? IDLE : CLEAR;
    end else if (bus.clr) begin
      state_n = CLEAR;
      cnt_n = '0;
    end
  end
  // array write port: clear sweep or lane-masked store
  always_ff @(posedge clk) begin
    if (busy)
      mem[cnt] <= '0;
    else if (st)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  // registered load captures pre-store data, so same-cycle store/load is read-first
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_q <= '0;
    else if (bus.RE && !busy)
      rd_q <= rd_c;
  end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: random and directed checks of both read modes against a byte-level model
module tb_data_memory_be;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  data_memory_be_if #(.TST_W(16)) bus0 ();
  data_memory_be_if #(.TST_W(16)) bus1 ();
  data_memory_be #(.DEPTH(D), .RD_REG(0), .TST_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  data_memory_be #(.DEPTH(D), .RD_REG(1), .TST_W(16)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  always #5 clk = ~clk;
  logic [31:0] mm [D];
  int busy_left = D;
  logic [31:0] rdq = '0;
  logic [31:0] a_i = '0, wd_i = '0;
  logic we_i = 0, re_i = 0, sgn_i = 0, clr_i = 0;
  logic [1:0] sz_i = '0;
  initial for (int i = 0; i < D; i++) mm[i] = '0;
  function automatic int nbytes(logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic m_mis(logic [31:0] a, logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction
  function automatic logic m_rerr(logic [31:0] a);
    return (a / 4) >= D;
  endfunction
  function automatic logic [31:0] m_load(logic [31:0] a, logic [1:0] sz, logic sgn);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = '0;
    if (m_mis(a, sz) || m_rerr(a)) return '0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[(a + i) / 4][8*((a + i) % 4) +: 8]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
    return v;
  endfunction
  function automatic logic m_busy();
    return rst || busy_left > 0;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(logic [31:0] a, logic [31:0] wd, logic we, logic re, logic [1:0] sz, logic sgn, logic cl);
    @(posedge clk);
    #2;
    a_i = a; wd_i = wd; we_i = we; re_i = re; sz_i = sz; sgn_i = sgn; clr_i = cl;
    bus0.A = a; bus0.WD = wd; bus0.WE = we; bus0.RE = re; bus0.SIZE = sz; bus0.SGN = sgn; bus0.clr = cl;
    bus1.A = a; bus1.WD = wd; bus1.WE = we; bus1.RE = re; bus1.SIZE = sz; bus1.SGN = sgn; bus1.clr = cl;
    #1;
  endtask
  task automatic count_busy(string name);
    int n;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus0.busy) break;
      n++;
    end
    chk(name, 32'(n), 32'(D));
  endtask
  always @(posedge clk) begin
    if (rst) begin
      busy_left = D;
      rdq = '0;
    end else if (busy_left > 0) begin
      mm[D - busy_left] = '0;
      busy_left--;
    end else begin
      if (re_i) rdq = m_load(a_i, sz_i, sgn_i);
      if (clr_i) busy_left = D;
      else if (we_i && !m_mis(a_i, sz_i) && !m_rerr(a_i))
        for (int i = 0; i < nbytes(sz_i); i++) mm[(a_i + i) / 4][8*((a_i + i) % 4) +: 8] = wd_i[8*i +: 8];
    end
  end
  always @(negedge clk) begin
    chk("busy0", 32'(bus0.busy), 32'(m_busy()));
    chk("busy1", 32'(bus1.busy), 32'(m_busy()));
    chk("misalign", 32'(bus0.misalign), 32'(m_mis(a_i, sz_i)));
    chk("range_err", 32'(bus1.range_err), 32'(m_rerr(a_i)));
    chk("rd_comb", bus0.RD, m_busy() ? 32'd0 : m_load(a_i, sz_i, sgn_i));
    chk("rd_reg", bus1.RD, m_busy() ? 32'd0 : rdq);
    chk("tst0", 32'(bus0.tst), m_busy() ? 32'd0 : 32'(mm[0][15:0]));
    chk("tst1", 32'(bus1.tst), m_busy() ? 32'd0 : 32'(mm[0][15:0]));
  end
  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    step(0, 0, 0, 0, 2'd2, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    count_busy("rst_busy_cycles");
    for (int w = 0; w < D; w++) begin
      step(32'(w * 4), 0, 0, 0, 2'd2, 0, 0);
      chk("cleared_word", bus0.RD, 32'd0);
    end
    chk("tst_after_clear", 32'(bus0.tst), 32'd0);
    step(32'h8, 32'h8899AABB, 1, 0, 2'd2, 0, 0);
    step(32'hB, 0, 0, 0, 2'd0, 1, 0);
    chk("byte_sgn", bus0.RD, 32'hFFFFFF88);
    chk("model_byte_sgn", m_load(32'hB, 2'd0, 1), 32'hFFFFFF88);
    step(32'hB, 0, 0, 0, 2'd0, 0, 0);
    chk("byte_zx", bus0.RD, 32'h00000088);
    step(32'h8, 0, 0, 0, 2'd1, 1, 0);
    chk("half_sgn", bus0.RD, 32'hFFFFAABB);
    chk("model_half_sgn", m_load(32'h8, 2'd1, 1), 32'hFFFFAABB);
    step(32'h9, 32'h5A, 1, 0, 2'd0, 0, 0);
    step(32'h8, 0, 0, 0, 2'd2, 0, 0);
    chk("byte_store", bus0.RD, 32'h88995ABB);
    chk("model_byte_store", m_load(32'h8, 2'd2, 0), 32'h88995ABB);
    step(32'h3, 32'hFFFF, 1, 0, 2'd1, 0, 0);
    chk("misalign_flag", 32'(bus0.misalign), 32'd1);
    step(32'h0, 0, 0, 0, 2'd2, 0, 0);
    chk("misalign_nowrite", bus0.RD, 32'd0);
    step(32'h40, 32'hDEADBEEF, 1, 0, 2'd2, 0, 0);
    chk("range_flag", 32'(bus0.range_err), 32'd1);
    chk("range_rd", bus0.RD, 32'd0);
    step(32'h0, 0, 0, 0, 2'd2, 0, 0);
    chk("range_nowrite", bus0.RD, 32'd0);
    step(32'h8, 32'h1234, 1, 1, 2'd2, 0, 0);
    step(32'h8, 0, 0, 1, 2'd2, 0, 0);
    chk("rdreg_readfirst", bus1.RD, 32'h88995ABB);
    step(32'h8, 0, 0, 0, 2'd2, 0, 0);
    chk("rdreg_new", bus1.RD, 32'h00001234);
    step(32'h0, 0, 0, 0, 2'd2, 0, 0);
    chk("rdreg_hold", bus1.RD, 32'h00001234);
    step(32'h0, 32'h77, 1, 0, 2'd2, 0, 1);
    step(32'h0, 0, 0, 0, 2'd2, 0, 0);
    chk("clr_busy_now", 32'(bus0.busy), 32'd1);
    count_busy("clr_busy_cycles");
    chk("clr_store_dropped", bus0.RD, 32'd0);
    step(32'h8, 0, 0, 0, 2'd2, 0, 0);
    chk("clr_zeroed", bus0.RD, 32'd0);
    step(32'h0, 0, 0, 0, 2'd2, 0, 1);
    step(32'h0, 0, 0, 0, 2'd2, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    count_busy("rst_mid_clear_cycles");
    for (int k = 0; k < 600; k++) begin
      a = $urandom_range(0, 4 * D + 7);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      sz = 2'($urandom_range(0, 3));
      step(a, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end
    step(0, 0, 0, 0, 2'd2, 0, 0);
    repeat (D + 2) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_be.md
DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words (power of 2, 4..4096).
REQ-002 SHALL have parameter ADDR_W, default $clog2(DEPTH), word-index width.
REQ-003 SHALL have parameter RD_REG, default 0; 0 = combinational read, 1 = registered read.
REQ-004 SHALL have parameter TST_W, default 16, debug tap width (1..32).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 A  in  32  byte address.
REQ-008 WD  in  32  store data, right-aligned.
REQ-009 WE  in  1  store strobe.
REQ-010 RE  in  1  load strobe (used when RD_REG=1).
REQ-011 SIZE  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-012 SGN  in  1  load sign-extend (1) / zero-extend (0) for byte and half.
REQ-013 clr  in  1  soft clear request.
REQ-014 RD  out  32  load data, right-aligned and extended.
REQ-015 busy  out  1  clear sequence in progress.
REQ-016 misalign  out  1  half at odd A, or word with A[1:0]!=0.
REQ-017 range_err  out  1  A[31:2] >= DEPTH.
REQ-018 tst  out  TST_W  word 0 bits [TST_W-1:0].

Function
REQ-019 Word index SHALL be A[ADDR_W+1:2]; byte lane SHALL be A[1:0].
REQ-020 Store (WE=1, busy=0, misalign=0, range_err=0) SHALL update only the addressed lanes on the rising clk edge: byte -> lane A[1:0] with WD[7:0]; half -> lanes A[1]*2..+1 with WD[15:0]; word -> all lanes.
REQ-021 Store with misalign=1 or range_err=1 SHALL leave memory unchanged.
REQ-022 misalign and range_err SHALL be combinational from A and SIZE, independent of WE/RE.
REQ-023 Load SHALL extract the addressed byte/half and extend per SGN; word loads ignore SGN.
REQ-024 Load with misalign=1 or range_err=1 SHALL return RD=0.
REQ-025 RD_REG=0: RD combinational from current A/SIZE/SGN; a same-address store becomes visible after the edge.
REQ-026 RD_REG=1: RD SHALL update one cycle after an edge with RE=1 and hold otherwise; same-cycle store to the same word SHALL return pre-store data (read-first).
REQ-027 FSM states CLEAR and IDLE; CLEAR SHALL write 0 to word cnt each cycle, cnt 0..DEPTH-1, then go to IDLE.
REQ-028 busy SHALL be 1 exactly while in CLEAR; WE and RE SHALL be ignored while busy=1, RD=0.
REQ-029 In IDLE, clr=1 SHALL enter CLEAR with cnt=0 on the next edge; clr together with WE: clr wins, store dropped.
REQ-030 clr while busy=1 SHALL be ignored (no restart).
REQ-031 tst SHALL equal word 0 [TST_W-1:0] when busy=0, and 0 when busy=1.

Reset
REQ-032 rst=1 SHALL asynchronously force state=CLEAR, cnt=0, busy=1, RD register=0.
REQ-033 The memory array SHALL not be reset directly; it is zeroed by the CLEAR sequence (DEPTH cycles after rst falls).
REQ-034 rst asserted mid-CLEAR SHALL restart the sequence at word 0.

Structure
REQ-035 Shared package dmem_pkg SHALL hold the SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-036 Lane logic (byte-enables, store replication, load extract/extend, misalign) SHALL be the combinational sub-module dmem_align.

Verification
REQ-037 rst pulse, DEPTH=16 -> busy=1 for 16 cycles after rst falls, then all words read 0, tst=0.
REQ-038 Word store 0x8899AABB at A=0x8; byte load A=0xB SGN=1 -> RD=0xFFFFFF88; SGN=0 -> 0x00000088; half load A=0x8 SGN=1 -> 0xFFFFAABB.
REQ-039 Byte store 0x5A at A=0x9 over 0x8899AABB -> word reads 0x88995ABB.
REQ-040 Half store at A=0x3 -> misalign=1, memory unchanged; A=DEPTH*4 (DEPTH=16, A=0x40) -> range_err=1, RD=0, no write.
REQ-041 RD_REG=1: store 0x1234 and RE to the same word in one cycle -> RD=old value next cycle, 0x1234 the cycle after with RE=1.
REQ-042 clr with WE in IDLE -> store dropped, busy=1 for DEPTH cycles; rst mid-clear -> busy restarts full DEPTH count.
